cic_interpolator: RTL and testbench

- Five-stage CIC interpolation filter, differential delay 1. It is the transmit-side counterpart of the receive-path CIC decimator.
- Accepts 12-bit signed samples at the low rate through a valid/ready handshake.
- Runs the comb section at the input rate, zero-stuffs by INTERP_RATIO, and integrates at the clk rate.
- Emits one scaled 12-bit sample every clk for the DAC/upconverter path.

---
 rtl/cic_interpolator.sv | 76 +++++++
 tb/tb_cic_interpolator.sv | 127 ++++++++++++
 2 files changed

// File: rtl/cic_interpolator.sv
// cic_interpolator: 5-stage CIC interpolator (R=INTERP_RATIO, M=1); define CIC_INTERP_SAT_EN to saturate d_out instead of wrapping.
module cic_interpolator #(
  parameter int WIDTH = 32,
  parameter int INTERP_RATIO = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  Gain,
  input  logic [11:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] d_out,
  output logic        out_valid,
  output logic        underrun
);
  localparam int PW = $clog2(INTERP_RATIO);
  localparam logic [PW-1:0] LAST = PW'(INTERP_RATIO - 1);
  localparam logic [7:0] HEAD = 8'(WIDTH - 12);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [PW-1:0] phase;
  logic [WIDTH-1:0] z [5];
  logic [WIDTH-1:0] integ [5];
  logic [WIDTH-1:0] c [6];
  logic [WIDTH-1:0] comb_out;
  logic [7:0] shift;
  logic [11:0] d_nx;
  logic slot, accept, starve, comb_en;
  always_comb begin
    slot = state == RUN && phase == LAST;
    in_ready = state == IDLE || slot;
    accept = in_valid && in_ready;
    starve = slot && !in_valid;
    comb_en = accept || starve;
    state_nx = accept ? RUN : state;
    c[0] = accept ? {{(WIDTH-12){in_data[11]}}, in_data} : '0;
    for (int k = 1; k < 6; k++) c[k] = c[k-1] - z[k-1];
    shift = Gain > HEAD ? 8'd0 : HEAD - Gain;
  end
`ifdef CIC_INTERP_SAT_EN
  logic [WIDTH-1:0] sh;
  assign sh = $signed(integ[4]) >>> shift;
  assign d_nx = (&sh[WIDTH-1:11] || ~|sh[WIDTH-1:11]) ? sh[11:0] : (sh[WIDTH-1] ? 12'h800 : 12'h7ff);
`else
  assign d_nx = 12'($signed(integ[4]) >>> shift);
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= '0;
      comb_out <= '0;
      d_out <= '0;
      out_valid <= 1'b0;
      underrun <= 1'b0;
      for (int k = 0; k < 5; k++) begin
        z[k] <= '0;
        integ[k] <= '0;
      end
    end else begin
      state <= state_nx;
      phase <= state == RUN ? phase + 1'b1 : '0;
      if (starve) underrun <= 1'b1;
      if (comb_en) begin
        for (int k = 0; k < 5; k++) z[k] <= c[k];
        comb_out <= c[5];
      end
      // zero-stuffing: the comb output enters the integrators only on phase 0
      if (state == RUN) begin
        integ[0] <= integ[0] + (phase == '0 ? comb_out : '0);
        for (int k = 1; k < 5; k++) integ[k] <= integ[k] + integ[k-1];
      end
      out_valid <= state == RUN;
      d_out <= d_nx;
    end
  end
endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator: directed checks of reset, impulse, step, handshake/underrun and output scaling.
module tb_cic_interpolator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] gain = 8'd20;
  logic [11:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready, out_valid, underrun;
  logic [11:0] d_out;
  int checks = 0;
  int passed = 0;
  int sum, rdy;
  cic_interpolator dut (
    .clk(clk), .rst_n(rst_n), .Gain(gain), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .d_out(d_out), .out_valid(out_valid), .underrun(underrun)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  function automatic int binom4(input int n);
    return (n + 1) * (n + 2) * (n + 3) * (n + 4) / 24;
  endfunction
  task automatic check_idle(input string tag);
    check({tag, "_ready"}, int'(in_ready), 1);
    check({tag, "_ovalid"}, int'(out_valid), 0);
    check({tag, "_dout"}, int'(d_out), 0);
    check({tag, "_underrun"}, int'(underrun), 0);
  endtask
  task automatic run_clks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check_idle("in_reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_idle("idle");
    // impulse with no scaling; in_valid held high in wrong phases, then dropped
    in_valid = 1'b1;
    in_data = 12'd1;
    gain = 8'd20;
    @(posedge clk);
    #1 in_data = 12'd777;
    sum = 0;
    for (int e = 1; e <= 110; e++) begin
      @(posedge clk);
      #1 if (e == 15) in_valid = 1'b0;
      @(negedge clk);
      if (e == 1) check("ovalid_run", int'(out_valid), 1);
      if (e == 14) check("ready_mid", int'(in_ready), 0);
      if (e == 15) begin
        check("ready_slot", int'(in_ready), 1);
        check("underrun_pre", int'(underrun), 0);
      end
      if (e == 16) check("underrun_set", int'(underrun), 1);
      if (e >= 6 && e <= 21) check($sformatf("imp%0d", e - 6), int'(d_out), binom4(e - 6));
      if (e >= 6 && e <= 105) sum += int'(d_out);
      if (e == 110) begin
        check("underrun_sticky", int'(underrun), 1);
        check("imp_tail", int'(d_out), 0);
      end
    end
    check("imp_sum_mod", sum % 4096, 65536 % 4096);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_idle("mid_reset");
    rst_n = 1'b1;
    // positive then negative step at unity gain
    gain = 8'd4;
    in_data = 12'd100;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rdy = 0;
    for (int e = 2; e <= 160; e++) begin
      @(posedge clk);
      @(negedge clk);
      rdy += int'(in_ready);
    end
    check("step_ready_pulses", rdy, 10);
    check("step_pos", int'($signed(d_out)), 100);
    check("step_ovalid", int'(out_valid), 1);
    check("step_underrun", int'(underrun), 0);
    @(posedge clk);
    #1 in_data = 12'hF9C;
    @(negedge clk);
    run_clks(160);
    check("step_neg", int'($signed(d_out)), -100);
    check("step_neg_underrun", int'(underrun), 0);
    // large constant input at reduced attenuation
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    gain = 8'd12;
    in_data = 12'd2047;
    in_valid = 1'b1;
    run_clks(170);
`ifdef CIC_INTERP_SAT_EN
    check("sat_gain12", int'($signed(d_out)), 2047);
`else
    check("sat_gain12", int'($signed(d_out)), -256);
`endif
    @(posedge clk);
    #1 gain = 8'd4;
    @(negedge clk);
    run_clks(1);
    check("gain_change", int'($signed(d_out)), 2047);
    @(posedge clk);
    #1 gain = 8'd30;
    @(negedge clk);
    run_clks(1);
`ifdef CIC_INTERP_SAT_EN
    check("gain_over", int'($signed(d_out)), 2047);
`else
    check("gain_over", int'($signed(d_out)), 0);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
